// File: rtl/imem_arbiter.sv
// Byte-wide instruction memory sequencer: splits 16-bit fetches and loads into two byte accesses.
// Define IMEM_ARB_RR_EN for round-robin tie-breaking; otherwise the loader wins every tie.
module imem_arbiter #(
    parameter int N = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    output logic        fetch_gnt,
    output logic        fetch_valid,
    output logic [15:0] fetch_instr,
    input  logic        load_valid,
    input  logic [15:0] load_addr,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    localparam logic [15:0] ADDR_MASK = 16'(N - 1);

    typedef enum logic [1:0] {IDLE, RD_HI, RD_LO, WR_LO} state_e;

    state_e      state_q, state_d;
    logic [15:0] addr_q;
    logic [15:0] addrNext;
    logic [7:0]  hiByte_q;
    logic [7:0]  loByte_q;
    logic [15:0] fetchInstr_q;
    logic        fetchValid_q;
    logic        grantFetch;
    logic        grantLoad;

`ifdef IMEM_ARB_RR_EN
    typedef enum logic {GRANT_FETCH, GRANT_LOAD} grant_e;
    grant_e lastGrant_q, lastGrant_d;
`endif

    // Second byte of every access; the mask makes a+1 wrap from N-1 to 0.
    assign addrNext = (addr_q + 16'd1) & ADDR_MASK;

    // Grants only exist in IDLE and are suppressed while reset is held.
    always_comb begin
        grantFetch = 1'b0;
        grantLoad  = 1'b0;
        if (!rst && state_q == IDLE) begin
`ifdef IMEM_ARB_RR_EN
            if (fetch_req && load_valid) begin
                if (lastGrant_q == GRANT_LOAD) grantFetch = 1'b1;
                else                           grantLoad  = 1'b1;
            end else begin
                grantFetch = fetch_req;
                grantLoad  = load_valid;
            end
`else
            grantLoad  = load_valid;
            grantFetch = fetch_req && !load_valid;
`endif
        end
    end

`ifdef IMEM_ARB_RR_EN
    always_comb begin
        lastGrant_d = lastGrant_q;
        if (grantFetch)     lastGrant_d = GRANT_FETCH;
        else if (grantLoad) lastGrant_d = GRANT_LOAD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lastGrant_q <= GRANT_FETCH;
        else     lastGrant_q <= lastGrant_d;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grantFetch)     state_d = RD_HI;
                else if (grantLoad) state_d = WR_LO;
            end
            RD_HI:   state_d = RD_LO;
            RD_LO:   state_d = IDLE;
            WR_LO:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fetch_gnt  = 1'b0;
        load_ready = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 16'd0;
        mem_wdata  = 8'd0;
        case (state_q)
            IDLE: begin
                if (grantFetch) begin
                    fetch_gnt = 1'b1;
                    mem_en    = 1'b1;
                    mem_addr  = fetch_addr & ADDR_MASK;
                end else if (grantLoad) begin
                    load_ready = 1'b1;
                    mem_en     = 1'b1;
                    mem_we     = 1'b1;
                    mem_addr   = load_addr & ADDR_MASK;
                    mem_wdata  = load_data[15:8];
                end
            end
            RD_HI: begin
                mem_en   = 1'b1;
                mem_addr = addrNext;
            end
            WR_LO: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addrNext;
                mem_wdata = loByte_q;
            end
            default: ;
        endcase
    end

    // Read data arrives one cycle after each strobe, so RD_HI sees the high byte and RD_LO the low byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= 16'd0;
            hiByte_q     <= 8'd0;
            loByte_q     <= 8'd0;
            fetchInstr_q <= 16'd0;
            fetchValid_q <= 1'b0;
        end else begin
            if (grantFetch) begin
                addr_q <= fetch_addr & ADDR_MASK;
            end else if (grantLoad) begin
                addr_q   <= load_addr & ADDR_MASK;
                loByte_q <= load_data[7:0];
            end
            if (state_q == RD_HI) hiByte_q <= mem_rdata;
            if (state_q == RD_LO) fetchInstr_q <= {hiByte_q, mem_rdata};
            fetchValid_q <= (state_q == RD_LO);
        end
    end

    assign fetch_valid = fetchValid_q;
    assign fetch_instr = fetchInstr_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a byte-wide synchronous-read memory model.
// Tie-break expectations follow IMEM_ARB_RR_EN when it is defined.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_valid;
    logic [15:0] fetch_instr;
    logic        load_valid;
    logic [15:0] load_addr;
    logic [15:0] load_data;
    logic        load_ready;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  tbMem [16];
    logic        preEn;
    logic [3:0]  preAddr;
    logic [7:0]  preData;

    int passCount  = 0;
    int checkCount = 0;

    wire [3:0] strobes = {fetch_gnt, load_ready, mem_en, mem_we};

    imem_arbiter #(.N(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_gnt  (fetch_gnt),
        .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr),
        .load_valid (load_valid),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_ready (load_ready),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // External array: one-cycle synchronous read, with a back door for preloading.
    always @(posedge clk) begin
        if (preEn) begin
            tbMem[preAddr] <= preData;
        end else if (mem_en) begin
            if (mem_we) tbMem[mem_addr[3:0]] <= mem_wdata;
            else        mem_rdata <= tbMem[mem_addr[3:0]];
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] a, input logic [7:0] d);
        preEn = 1'b1; preAddr = a; preData = d;
        step();
        preEn = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_req = 1'b1; load_valid = 1'b1;
        fetch_addr = 16'd2; load_addr = 16'd4; load_data = 16'hFFFF;
        #1;
        checkCount++;
        if ({strobes, mem_addr, mem_wdata, fetch_valid, fetch_instr} !== 45'd0)
            $display("FAIL reset_outputs: got %h want 0", {strobes, mem_addr, mem_wdata, fetch_valid, fetch_instr});
        else passCount++;
        step();
        checkCount++;
        if ({strobes, mem_addr, mem_wdata, fetch_valid, fetch_instr} !== 45'd0)
            $display("FAIL reset_held: got %h want 0", {strobes, mem_addr, mem_wdata, fetch_valid, fetch_instr});
        else passCount++;
        fetch_req = 1'b0; load_valid = 1'b0; rst = 1'b0;
        #1;
        checkCount++;
        if ({strobes, mem_addr} !== 20'd0)
            $display("FAIL idle_after_reset: got %h want 0", {strobes, mem_addr});
        else passCount++;
    endtask

    task automatic test_fetch();
        preload(4'd2, 8'h60);
        preload(4'd3, 8'h02);
        fetch_req = 1'b1; fetch_addr = 16'd2;
        #1;
        checkCount++;
        if ({strobes, mem_addr} !== {4'b1010, 16'd2})
            $display("FAIL fetch_grant: got %h want %h", {strobes, mem_addr}, {4'b1010, 16'd2});
        else passCount++;
        step();
        fetch_req = 1'b0;
        #1;
        checkCount++;
        if ({strobes, mem_addr} !== {4'b0010, 16'd3})
            $display("FAIL fetch_rd_lo_addr: got %h want %h", {strobes, mem_addr}, {4'b0010, 16'd3});
        else passCount++;
        step();
        checkCount++;
        if ({strobes, fetch_valid} !== 5'b0)
            $display("FAIL fetch_t2_quiet: got %b want 0", {strobes, fetch_valid});
        else passCount++;
        step();
        checkCount++;
        if ({fetch_valid, fetch_instr} !== {1'b1, 16'h6002})
            $display("FAIL fetch_valid_t3: got %h want %h", {fetch_valid, fetch_instr}, {1'b1, 16'h6002});
        else passCount++;
        step();
        checkCount++;
        if ({fetch_valid, fetch_instr} !== {1'b0, 16'h6002})
            $display("FAIL fetch_instr_hold: got %h want %h", {fetch_valid, fetch_instr}, {1'b0, 16'h6002});
        else passCount++;
    endtask

    task automatic test_load();
        load_valid = 1'b1; load_addr = 16'd4; load_data = 16'hD004;
        #1;
        checkCount++;
        if ({strobes, mem_addr, mem_wdata} !== {4'b0111, 16'd4, 8'hD0})
            $display("FAIL load_hi_write: got %h want %h", {strobes, mem_addr, mem_wdata}, {4'b0111, 16'd4, 8'hD0});
        else passCount++;
        step();
        load_valid = 1'b0;
        #1;
        checkCount++;
        if ({strobes, mem_addr, mem_wdata} !== {4'b0011, 16'd5, 8'h04})
            $display("FAIL load_lo_write: got %h want %h", {strobes, mem_addr, mem_wdata}, {4'b0011, 16'd5, 8'h04});
        else passCount++;
        step();
        checkCount++;
        if ({strobes, tbMem[4], tbMem[5]} !== {4'b0000, 16'hD004})
            $display("FAIL load_mem_contents: got %h want %h", {strobes, tbMem[4], tbMem[5]}, {4'b0000, 16'hD004});
        else passCount++;
        fetch_req = 1'b1; fetch_addr = 16'd4;
        #1;
        checkCount++;
        if (strobes !== 4'b1010)
            $display("FAIL load_refetch_grant: got %b want 1010", strobes);
        else passCount++;
        step();
        fetch_req = 1'b0;
        step();
        step();
        checkCount++;
        if ({fetch_valid, fetch_instr} !== {1'b1, 16'hD004})
            $display("FAIL load_refetch_data: got %h want %h", {fetch_valid, fetch_instr}, {1'b1, 16'hD004});
        else passCount++;
    endtask

    task automatic test_wrap();
        preload(4'd15, 8'h11);
        preload(4'd0, 8'h10);
        fetch_req = 1'b1; fetch_addr = 16'd15;
        #1;
        checkCount++;
        if ({strobes, mem_addr} !== {4'b1010, 16'd15})
            $display("FAIL wrap_first_addr: got %h want %h", {strobes, mem_addr}, {4'b1010, 16'd15});
        else passCount++;
        step();
        fetch_req = 1'b0;
        #1;
        checkCount++;
        if (mem_addr !== 16'd0)
            $display("FAIL wrap_second_addr: got %h want 0000", mem_addr);
        else passCount++;
        step();
        step();
        checkCount++;
        if ({fetch_valid, fetch_instr} !== {1'b1, 16'h1110})
            $display("FAIL wrap_instr: got %h want %h", {fetch_valid, fetch_instr}, {1'b1, 16'h1110});
        else passCount++;
        fetch_req = 1'b1; fetch_addr = 16'hFFF3;
        #1;
        checkCount++;
        if ({strobes, mem_addr} !== {4'b1010, 16'd3})
            $display("FAIL high_bits_masked: got %h want %h", {strobes, mem_addr}, {4'b1010, 16'd3});
        else passCount++;
        step();
        fetch_req = 1'b0;
        #1;
        checkCount++;
        if (mem_addr !== 16'd4)
            $display("FAIL odd_second_addr: got %h want 0004", mem_addr);
        else passCount++;
        step();
        step();
        checkCount++;
        if ({fetch_valid, fetch_instr} !== {1'b1, 16'h02D0})
            $display("FAIL odd_instr: got %h want %h", {fetch_valid, fetch_instr}, {1'b1, 16'h02D0});
        else passCount++;
    endtask

    task automatic test_back_to_back();
        fetch_req = 1'b1; fetch_addr = 16'd2;
        #1;
        checkCount++;
        if (strobes !== 4'b1010)
            $display("FAIL b2b_first_grant: got %b want 1010", strobes);
        else passCount++;
        step();
        fetch_addr = 16'd4;
        #1;
        checkCount++;
        if (strobes !== 4'b0010)
            $display("FAIL b2b_no_grant_rd_hi: got %b want 0010", strobes);
        else passCount++;
        step();
        checkCount++;
        if (strobes !== 4'b0000)
            $display("FAIL b2b_no_grant_rd_lo: got %b want 0000", strobes);
        else passCount++;
        step();
        checkCount++;
        if ({strobes, mem_addr, fetch_valid, fetch_instr} !== {4'b1010, 16'd4, 1'b1, 16'h6002})
            $display("FAIL b2b_regrant_t3: got %h want %h", {strobes, mem_addr, fetch_valid, fetch_instr}, {4'b1010, 16'd4, 1'b1, 16'h6002});
        else passCount++;
        step();
        fetch_req = 1'b0;
        step();
        step();
        checkCount++;
        if ({fetch_valid, fetch_instr} !== {1'b1, 16'hD004})
            $display("FAIL b2b_second_instr: got %h want %h", {fetch_valid, fetch_instr}, {1'b1, 16'hD004});
        else passCount++;
    endtask

    task automatic test_tie();
        logic [1:0] expTie [6];
`ifdef IMEM_ARB_RR_EN
        expTie = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
`else
        expTie = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
`endif
        rst = 1'b1;
        #1;
        rst = 1'b0;
        fetch_req = 1'b1; fetch_addr = 16'd2;
        load_valid = 1'b1; load_addr = 16'd8; load_data = 16'h1234;
        #1;
        for (int i = 0; i < 6; i++) begin
            checkCount++;
            if ({fetch_gnt, load_ready} !== expTie[i])
                $display("FAIL tie_cycle%0d: got gnt/ready %b want %b", i, {fetch_gnt, load_ready}, expTie[i]);
            else passCount++;
            step();
        end
        fetch_req = 1'b0; load_valid = 1'b0;
        step();
        step();
        step();
        checkCount++;
        if ({tbMem[8], tbMem[9]} !== 16'h1234)
            $display("FAIL tie_load_written: got %h want 1234", {tbMem[8], tbMem[9]});
        else passCount++;
    endtask

    task automatic test_reset_wr();
        preload(4'd6, 8'h00);
        preload(4'd7, 8'h00);
        load_valid = 1'b1; load_addr = 16'd6; load_data = 16'hABCD;
        #1;
        checkCount++;
        if (strobes !== 4'b0111)
            $display("FAIL rstwr_grant: got %b want 0111", strobes);
        else passCount++;
        step();
        load_valid = 1'b0; rst = 1'b1;
        #1;
        checkCount++;
        if ({strobes, mem_addr, mem_wdata, fetch_valid, fetch_instr} !== 45'd0)
            $display("FAIL rstwr_outputs: got %h want 0", {strobes, mem_addr, mem_wdata, fetch_valid, fetch_instr});
        else passCount++;
        step();
        rst = 1'b0;
        #1;
        step();
        checkCount++;
        if ({strobes, tbMem[6], tbMem[7]} !== {4'b0000, 16'hAB00})
            $display("FAIL rstwr_partial_write: got %h want %h", {strobes, tbMem[6], tbMem[7]}, {4'b0000, 16'hAB00});
        else passCount++;
    endtask

    task automatic test_reset_rd();
        fetch_req = 1'b1; fetch_addr = 16'd2;
        #1;
        checkCount++;
        if (strobes !== 4'b1010)
            $display("FAIL rstrd_grant: got %b want 1010", strobes);
        else passCount++;
        step();
        fetch_req = 1'b0; rst = 1'b1;
        #1;
        checkCount++;
        if ({strobes, mem_addr} !== 20'd0)
            $display("FAIL rstrd_outputs: got %h want 0", {strobes, mem_addr});
        else passCount++;
        step();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checkCount++;
            if ({fetch_valid, fetch_instr} !== 17'd0)
                $display("FAIL rstrd_no_valid%0d: got %h want 0", i, {fetch_valid, fetch_instr});
            else passCount++;
            step();
        end
        fetch_req = 1'b1; fetch_addr = 16'd2;
        #1;
        checkCount++;
        if (strobes !== 4'b1010)
            $display("FAIL rstrd_reissue_grant: got %b want 1010", strobes);
        else passCount++;
        step();
        fetch_req = 1'b0;
        step();
        step();
        checkCount++;
        if ({fetch_valid, fetch_instr} !== {1'b1, 16'h6002})
            $display("FAIL rstrd_reissue_data: got %h want %h", {fetch_valid, fetch_instr}, {1'b1, 16'h6002});
        else passCount++;
    endtask

    initial begin
        rst = 1'b1; fetch_req = 1'b0; fetch_addr = 16'd0;
        load_valid = 1'b0; load_addr = 16'd0; load_data = 16'd0;
        preEn = 1'b0; preAddr = 4'd0; preData = 8'd0;
        @(negedge clk);
        test_reset();
        test_fetch();
        test_load();
        test_wrap();
        test_back_to_back();
        test_tie();
        test_reset_wr();
        test_reset_rd();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Sequencer and arbiter for the byte-wide, single-port instruction memory. Shares the memory between the pipeline fetch stage (16-bit instruction reads) and the program loader (16-bit instruction writes), splitting each access into two byte cycles, high byte at address `a` and low byte at `a+1`. Sits between IF-stage / loader and the memory array; the array itself is external with a synchronous one-cycle read.

## Interface
- `N`, 16: memory depth in bytes; power of two, ≥ 2.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `fetch_req` input 1: fetch request; held with `fetch_addr` until `fetch_gnt`.
- `fetch_addr` input 16: byte address of the instruction's high byte.
- `fetch_gnt` output 1: fetch accepted this cycle.
- `fetch_valid` output 1: one-cycle pulse, `fetch_instr` valid.
- `fetch_instr` output 16: `{mem[a], mem[a+1]}`; holds until the next `fetch_valid`.
- `load_valid` input 1: loader write request; held with address and data until `load_ready`.
- `load_addr` input 16: byte address for the high byte.
- `load_data` input 16: instruction to write.
- `load_ready` output 1: write accepted this cycle.
- `mem_en` output 1: memory access strobe.
- `mem_we` output 1: write enable; qualifies `mem_en`.
- `mem_addr` output 16: byte address, always `addr & (N-1)`.
- `mem_wdata` output 8: write byte.
- `mem_rdata` input 8: read byte, valid the cycle after a read strobe.

## Operation
- States: IDLE, RD_HI, RD_LO, WR_LO.
- IDLE: grant decision is combinational on `fetch_req`/`load_valid`.
  - Fetch granted: `fetch_gnt`=1, `mem_en`=1, `mem_we`=0, `mem_addr`=`fetch_addr`; latch address; go to RD_HI.
  - Load granted: `load_ready`=1, `mem_en`=1, `mem_we`=1, `mem_wdata`=`load_data[15:8]`; latch address and low byte; go to WR_LO.
  - Neither request: all strobes 0; stay in IDLE.
- RD_HI: capture `mem_rdata` as the high byte; read strobe at `a+1`; go to RD_LO.
- RD_LO: register `fetch_instr` = `{hi, mem_rdata}`; `fetch_valid`=1 on the next cycle; go to IDLE.
- WR_LO: write strobe at `a+1` with the latched low byte; go to IDLE.
- Address rules:
  - `a+1` computed modulo N, so `a` = N-1 wraps to 0.
  - Odd (unaligned) addresses are legal and handled identically.
  - Address bits ≥ log2(N) are ignored.
- Arbitration on simultaneous requests is set by the macro (see Configuration).
- `last_grant` register records which requester won the last grant.
- Requests arriving outside IDLE wait; no grant is issued outside IDLE.

## Timing
- Fetch accepted in cycle T: reads at T and T+1; `fetch_valid` high in T+3. IDLE is re-entered in T+3, so a new grant is possible in T+3 (throughput 1 fetch / 3 cycles).
- Load accepted in cycle T: high byte written at T, low byte at T+1; IDLE in T+2, so throughput 1 load / 2 cycles.
- `fetch_gnt`, `load_ready` and `mem_*` outputs are combinational from state, latched registers and inputs. They never glitch high outside IDLE, except for the `mem_*` strobes of the current state.
- Reset values, held while `rst`=1:
  - state IDLE, `last_grant`=FETCH.
  - Outputs: `fetch_gnt`, `fetch_valid`, `load_ready`, `mem_en`, `mem_we` = 0; `fetch_instr`, `mem_addr`, `mem_wdata` = 0.
- Reset mid-operation:
  - Aborts immediately; no `fetch_valid` for the aborted fetch.
  - A write interrupted in WR_LO leaves only the high byte written; the loader must reissue the write.

## Configuration
- `IMEM_ARB_RR_EN` defined: round-robin. A tie goes to the requester that did not win the last grant; `last_grant` updates on every grant.
- `IMEM_ARB_RR_EN` undefined: fixed priority, loader always wins ties; `last_grant` is unused.

## Test plan
- Preload mem[2]=8'h60, mem[3]=8'h02; fetch addr 2 → `fetch_gnt` at T, `mem_addr` 2 then 3, `fetch_valid` at T+3 with `fetch_instr`=16'h6002.
- Load addr 4, data 16'hD004 → `load_ready` at T; write 8'hD0 at addr 4 (T) and 8'h04 at addr 5 (T+1); a following fetch of addr 4 returns 16'hD004.
- N=16, fetch addr 15 with mem[15]=8'h11, mem[0]=8'h10 → `mem_addr` 15 then 0; `fetch_instr`=16'h1110.
- Both requesters held continuously under `IMEM_ARB_RR_EN` → grants alternate load, fetch, load… (first tie goes to loader after reset). Without the macro → only loader grants while `load_valid` stays high.
- Assert `rst` in WR_LO of a load of 16'hABCD to addr 6 → only mem[6]=8'hAB written; all outputs 0 during reset; IDLE after release.
- Assert `rst` in RD_HI → no `fetch_valid`; a fetch reissued after release completes normally in 3 cycles.
